// File: rtl/base3_conv_arbiter.sv
// Round-robin arbiter that shares one base2_to_base3 converter among NUM_REQ requesters,
// with a watchdog and a post-reset resync of the converter, which has no reset of its own.
module base3_conv_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned width      = 16,
  parameter int unsigned base_width = 2,
  parameter int unsigned TIMEOUT    = 63
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*width-1:0]    req_data,
  output logic [NUM_REQ-1:0]          res_valid,
  output logic [base_width*width-1:0] res_data,
  output logic                        res_err,
  output logic                        busy,
  output logic                        conv_en,
  output logic [width-1:0]            conv_no,
  input  logic                        conv_done,
  input  logic [base_width*width-1:0] conv_base3
);

  localparam int unsigned IW  = $clog2(NUM_REQ);
  localparam int unsigned SW  = IW + 1;
  localparam int unsigned RW  = base_width * width;
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_SYNC    = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_DELIVER = 3'd4;

  logic [2:0]         state, state_nxt;
  logic [IW-1:0]      ptr, ptr_nxt;
  logic [IW-1:0]      gnt, gnt_nxt;
  logic [WDW-1:0]     wd, wd_nxt, wd_inc;
  logic [NUM_REQ-1:0] res_valid_nxt;
  logic [RW-1:0]      res_data_nxt;
  logic               res_err_nxt;
  logic               busy_nxt;
  logic               conv_en_nxt;
  logic [width-1:0]   conv_no_nxt;
  logic [SW-1:0]      sum;
  logic               found;
  logic [IW-1:0]      pick;

  // Next-state and next-output logic; the round-robin search only matters in IDLE.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    gnt_nxt       = gnt;
    wd_inc        = wd + WDW'(1);
    wd_nxt        = wd;
    res_valid_nxt = '0;
    res_data_nxt  = res_data;
    res_err_nxt   = 1'b0;
    conv_en_nxt   = 1'b0;
    conv_no_nxt   = conv_no;
    sum           = '0;
    found         = 1'b0;
    pick          = '0;

    for (int i = 0; i < NUM_REQ; i++) begin
      sum = SW'(ptr) + SW'(i);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end

    case (state)
      S_SYNC: begin
        wd_nxt = wd_inc;
        if (conv_done || (wd_inc == WDW'(TIMEOUT))) begin
          wd_nxt    = '0;
          state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (found) begin
          gnt_nxt     = pick;
          conv_no_nxt = req_data[32'(pick) * width +: width];
          conv_en_nxt = 1'b1;
          state_nxt   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_nxt    = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        wd_nxt = wd_inc;
        // A done arriving on the expiry cycle still wins over the timeout.
        if (conv_done) begin
          res_data_nxt  = conv_base3;
          res_valid_nxt = NUM_REQ'(1) << gnt;
          state_nxt     = S_DELIVER;
        end else if (wd_inc == WDW'(TIMEOUT)) begin
          res_data_nxt  = '0;
          res_err_nxt   = 1'b1;
          res_valid_nxt = NUM_REQ'(1) << gnt;
          state_nxt     = S_DELIVER;
        end
      end
      S_DELIVER: begin
        ptr_nxt   = (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + IW'(1);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_SYNC;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_SYNC;
      ptr       <= '0;
      gnt       <= '0;
      wd        <= '0;
      res_valid <= '0;
      res_data  <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b1;
      conv_en   <= 1'b0;
      conv_no   <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      wd        <= wd_nxt;
      res_valid <= res_valid_nxt;
      res_data  <= res_data_nxt;
      res_err   <= res_err_nxt;
      busy      <= busy_nxt;
      conv_en   <= conv_en_nxt;
      conv_no   <= conv_no_nxt;
    end
  end

endmodule

// File: tb/tb_base3_conv_arbiter.sv
// Bench for base3_conv_arbiter: converter stub with programmable latency, directed scenarios
// and a randomized phase, all checked against a round-robin / base-3 reference model.
module tb_base3_conv_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int BW = 2;
  localparam int RW = BW * W;
  localparam int TO = 63;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]  res_valid;
  logic [RW-1:0] res_data;
  logic          res_err;
  logic          busy;
  logic          conv_en;
  logic [W-1:0]  conv_no;
  logic          conv_done;
  logic [RW-1:0] conv_base3;

  // Converter stub
  logic          stub_done = 1'b0;
  logic [RW-1:0] stub_b3 = '0;
  logic          stub_pend = 1'b0;
  int            stub_cnt = 0;
  logic [W-1:0]  stub_op = '0;
  bit            stub_hang = 1'b0;
  int            stub_fixed = 0;
  logic          inj_done = 1'b0;

  // Reference model state
  int            n_cmp = 0;
  int            n_err = 0;
  int            mptr = 0;
  int            exp_g = -1;
  logic [W-1:0]  exp_op = '0;
  bit            exp_to = 1'b0;
  bit            in_flight = 1'b0;
  bit            scramble = 1'b0;
  logic          prev_en = 1'b0;
  int            cyc = 0;
  int            last_en_cycle = 0;
  int            last_rv_cycle = 0;
  logic [RW-1:0] last_res = '0;
  logic          last_err = 1'b0;
  int            grants[$];
  int            n;

  base3_conv_arbiter #(.NUM_REQ(N), .width(W), .base_width(BW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_err    (res_err),
    .busy       (busy),
    .conv_en    (conv_en),
    .conv_no    (conv_no),
    .conv_done  (conv_done),
    .conv_base3 (conv_base3)
  );

  always #5 clk = ~clk;

  assign conv_done  = stub_done | inj_done;
  assign conv_base3 = inj_done ? '0 : stub_b3;

  function automatic logic [RW-1:0] to_base3(input logic [W-1:0] v);
    logic [RW-1:0] r;
    int unsigned   q;
    r = '0;
    q = int'(v);
    for (int d = 0; d < W; d++) begin
      r[d*BW +: BW] = BW'(q % 3);
      q = q / 3;
    end
    return r;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic int first_one(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[k]) return k;
    return -1;
  endfunction

  // Stub: responds stub_fixed (or random 1..26) edges after seeing en, unless hung.
  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (conv_en && !stub_hang) begin
      stub_pend <= 1'b1;
      stub_op   <= conv_no;
      stub_cnt  <= (stub_fixed > 0) ? stub_fixed : int'($urandom_range(26, 1));
    end else if (stub_pend) begin
      if (stub_cnt == 1) begin
        stub_done <= 1'b1;
        stub_b3   <= to_base3(stub_op);
        stub_pend <= 1'b0;
      end
      stub_cnt <= stub_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge, predict grants and results, act as requesters.
  task automatic tick();
    int g;
    @(negedge clk);
    cyc++;
    if (conv_en) begin
      check("en_pulse", 64'(prev_en), 64'd0);
      exp_g = rr_pick(req, mptr);
      check("grant_exists", 64'(exp_g >= 0), 64'd1);
      if (exp_g >= 0) begin
        exp_op = req_data[exp_g*W +: W];
        check("conv_no", 64'(conv_no), 64'(exp_op));
        if (scramble && $urandom_range(1, 0) == 1) req_data[exp_g*W +: W] = ~exp_op;
      end
      in_flight     = 1'b1;
      last_en_cycle = cyc;
    end
    if (res_valid != '0) begin
      g = first_one(res_valid);
      check("rv_expected", 64'(in_flight), 64'd1);
      check("res_valid", 64'(res_valid), 64'(onehot(exp_g)));
      check("res_err", 64'(res_err), 64'(exp_to));
      check("res_data", 64'(res_data), exp_to ? 64'd0 : 64'(to_base3(exp_op)));
      grants.push_back(g);
      last_res      = res_data;
      last_err      = res_err;
      last_rv_cycle = cyc;
      req           = req & ~res_valid;
      if (exp_g >= 0) mptr = (exp_g + 1) % N;
      in_flight     = 1'b0;
    end
    prev_en = conv_en;
  endtask

  task automatic run_req(input logic [N-1:0] mask, input int budget);
    int k;
    k = 0;
    req = req | mask;
    while ((req != '0 || in_flight || busy) && k < budget) begin
      tick();
      k++;
    end
    check("drain", 64'(req), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    // Reset values, then resync ends by watchdog when the converter stays silent
    repeat (3) @(negedge clk);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_err", 64'(res_err), 64'd0);
    check("rst_conv_en", 64'(conv_en), 64'd0);
    check("rst_conv_no", 64'(conv_no), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("sync_len", 64'(n), 64'(TO));

    // Directed single conversions
    req_data[0*W +: W] = 16'd26;
    run_req(4'b0001, 200);
    check("tp_26", 64'(last_res), 64'h2A);
    check("tp_26_err", 64'(last_err), 64'd0);
    req_data[2*W +: W] = 16'd5;
    run_req(4'b0100, 200);
    check("tp_5", 64'(last_res), 64'h06);
    req_data[2*W +: W] = 16'd0;
    run_req(4'b0100, 200);
    check("tp_0", 64'(last_res), 64'd0);
    req_data[3*W +: W] = 16'd1000;
    run_req(4'b1000, 200);

    // Round-robin order with pointer at 0
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    grants.delete();
    run_req(4'b1111, 400);
    check("order_cnt", 64'(grants.size()), 64'd4);
    if (grants.size() == 4)
      for (int i = 0; i < 4; i++) check("order_1111", 64'(grants[i]), 64'(i));
    grants.delete();
    run_req(4'b1001, 200);
    check("order_cnt2", 64'(grants.size()), 64'd2);
    if (grants.size() == 2) begin
      check("order_1001_a", 64'(grants[0]), 64'd0);
      check("order_1001_b", 64'(grants[1]), 64'd3);
    end

    // Watchdog timeout, then a normal completion
    stub_hang = 1'b1;
    exp_to    = 1'b1;
    req_data[1*W +: W] = 16'hBEEF;
    run_req(4'b0010, 200);
    check("to_lat", 64'(last_rv_cycle - last_en_cycle), 64'(TO + 1));
    check("to_err", 64'(last_err), 64'd1);
    check("to_data", 64'(last_res), 64'd0);
    stub_hang = 1'b0;
    exp_to    = 1'b0;
    req_data[1*W +: W] = 16'd4321;
    run_req(4'b0010, 200);
    check("after_to_err", 64'(last_err), 64'd0);

    // Reset mid-WAIT, stray done 5 cycles after release ends resync
    stub_hang = 1'b1;
    req_data[2*W +: W] = 16'd1234;
    req = 4'b0100;
    repeat (10) tick();
    check("mid_wait_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    req = '0;
    in_flight = 1'b0;
    mptr = 0;
    repeat (2) tick();
    check("in_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("resync_busy", 64'(busy), 64'd1);
    end
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    check("resync_idle", 64'(busy), 64'd0);
    stub_hang = 1'b0;
    req_data[2*W +: W] = 16'd777;
    grants.delete();
    run_req(4'b0100, 200);
    check("post_rst_data", 64'(last_res), 64'(to_base3(16'd777)));
    check("post_rst_cnt", 64'(grants.size()), 64'd1);

    // Done on the very cycle the watchdog expires
    stub_fixed = TO - 1;
    req_data[0*W +: W] = 16'd59048;
    run_req(4'b0001, 200);
    check("coinc_err", 64'(last_err), 64'd0);
    check("coinc_lat", 64'(last_rv_cycle - last_en_cycle), 64'(TO + 1));
    check("coinc_data", 64'(last_res), 64'(to_base3(16'd59048)));
    stub_fixed = 0;

    // Stray done in IDLE is ignored
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    check("stray_idle_busy", 64'(busy), 64'd0);
    tick();
    check("stray_idle_busy2", 64'(busy), 64'd0);

    // Randomized traffic with late operand changes from the granted requester
    scramble = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(3, 0) == 0) begin
          req_data[i*W +: W] = W'($urandom);
          req[i] = 1'b1;
        end
      tick();
    end
    run_req('0, 1000);
    scramble = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/base3_conv_arbiter.md
Name: base3_conv_arbiter

Overview:
- Shares one base2_to_base3 converter instance among NUM_REQ requesters, such as the message-symbol and key-stream producers of the hiding pipeline.
- Selects requesters round-robin, issues a single-cycle en pulse with the selected operand, and waits for the converter's done pulse.
- Delivers the base-3 result to the granted requester over a shared result bus with a one-hot valid.
- Provides a watchdog timeout and a post-reset resynchronisation of the converter, which has no reset of its own.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- width, 16, operand width in bits, matching the converter.
- base_width, 2, bits per base-3 digit, matching the converter.
- TIMEOUT, 63, maximum WAIT cycles before an error completion (fits 6 bits; must exceed the worst-case converter latency, about 26 cycles for width=16).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  level request per requester; held until that requester's res_valid.
- req_data  in  NUM_REQ*width  operand of requester i at [i*width +: width]; stable while req[i]=1.
- res_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- res_data  out  base_width*width  base-3 result; valid only while res_valid!=0.
- res_err  out  1  qualifies res_valid: conversion timed out, res_data=0.
- busy  out  1  high in every state except IDLE.
- conv_en  out  1  converter en.
- conv_no  out  width  converter base2_no.
- conv_done  in  1  converter done.
- conv_base3  in  base_width*width  converter base3_no.

Behaviour:
- Reset (async assert, sync release). Outputs go to res_valid=0, res_data=0, res_err=0, conv_en=0, conv_no=0, busy=1. Internal state: rr pointer=0, watchdog counter=0, state=SYNC.
- All outputs are registered.

- SYNC: flushes a conversion that may be in flight from before reset.
  - Exit to IDLE on the first conv_done=1, or after TIMEOUT cycles.
  - No result is delivered.

- IDLE: req is sampled only in this state.
  - If req!=0, grant the first set bit searching from index ptr upward with wrap-around.
  - Latch the grant index and load conv_no=req_data[g]. Go to ISSUE.
  - A stray conv_done in IDLE is ignored.

- ISSUE: conv_en=1 for exactly this cycle. Clear the watchdog. Go to WAIT.

- WAIT: the watchdog increments each cycle.
  - conv_done=1: latch conv_base3 into res_data, res_err=0, go to DELIVER.
  - Otherwise, if the watchdog reaches TIMEOUT: res_data=0, res_err=1, go to DELIVER.
  - conv_done takes priority over timeout in the same cycle.

- DELIVER: res_valid[g]=1 for this cycle only. Set ptr=(g+1) mod NUM_REQ. Go to IDLE.
  - Outside DELIVER, res_valid=0 and res_err=0; res_data holds its last value.

- Requester rule: drop req[g] on the edge where res_valid[g] is seen. A req[g] still high in IDLE is a new request.

- Latency:
  - req seen at IDLE edge k gives conv_en high in cycle k+1.
  - conv_done sampled at edge m gives res_valid high in cycle m+1.
  - Minimum turnaround back to IDLE is 2 cycles after conv_done.

- Operand 0 is legal; its result is 0.
- Changes to req_data for the granted requester after the IDLE sample have no effect.
- Reset asserted in any state aborts the transaction with no res_valid and re-enters SYNC.

Test Plan:
- req=4'b0001, req_data[0]=26 → conv_en one cycle; res_valid=4'b0001, res_data=0x002A (digits 2,2,2), res_err=0.
- req=4'b0100, data=5 → res_valid=4'b0100, res_data=0x0006 (digits 2,1). data=0 → res_data=0.
- req=4'b1111 held, each requester dropping after its pulse → grants in order 0,1,2,3. Then req=4'b1001 with ptr=0 → grant 0, then 3.
- Converter stub that never raises conv_done → res_valid pulse exactly TIMEOUT+1 cycles after conv_en, with res_err=1 and res_data=0. A following request completes normally.
- Reset asserted mid-WAIT; the stub then emits a stray conv_done 5 cycles after release → no res_valid, busy until that done, then IDLE. The next request gets the correct result.
- conv_done and watchdog expiry in the same cycle → res_err=0, converter result delivered.
